// File: rtl/rr_sample_arbiter.sv
// Four-requester arbiter that grants one requester at a time. A grant is held
// for HOLD cycles and then the winner's data slice is sampled. If the winner
// drops its request before the hold ends, the grant is aborted.
// mode selects round-robin (00/01), fixed priority (11) or frozen (10).
module rr_sample_arbiter #(
  parameter int HOLD = 2,  // grant-hold cycles before sampling, 1..15
  parameter int W    = 1   // per-requester data width
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [3:0]     req,
  input  logic [4*W-1:0] din,
  input  logic [1:0]     mode,
  output logic [3:0]     gnt,
  output logic           busy,
  output logic [W-1:0]   dout,
  output logic           dvalid,
  output logic           abort
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    SAMPLE = 2'd2
  } state_t;

  localparam logic [1:0] MODE_FROZEN = 2'b10;
  localparam logic [1:0] MODE_FIXED  = 2'b11;
  localparam logic [3:0] HOLD_LOAD   = 4'(HOLD - 1);

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;      // remaining GRANT cycles after this one
  logic [1:0]     ptr_q, ptr_d;      // last round-robin winner
  logic [1:0]     idx_q, idx_d;      // index of the requester holding the grant
  logic [3:0]     gnt_d;
  logic [W-1:0]   dout_d;
  logic           dvalid_d, abort_d;
  logic [1:0]     rr_idx, fp_idx;

  assign busy = (state_q != IDLE);

  // Pick the round-robin and the fixed-priority candidates from the current requests.
  always_comb begin
    // NOTE: every always_comb output gets a default first so that no path leaves it unassigned, which would infer a latch.
    rr_idx = ptr_q;
    fp_idx = 2'd0;
    // Walk downward so the last hit is the closest requester above ptr.
    for (int i = 4; i >= 1; i--) begin
      if (req[ptr_q + 2'(i)]) rr_idx = ptr_q + 2'(i);
    end
    // The lowest index wins under fixed priority.
    for (int i = 3; i >= 0; i--) begin
      if (req[i]) fp_idx = 2'(i);
    end
  end

  // Next-state and next-output logic for the IDLE/GRANT/SAMPLE controller.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    gnt_d    = gnt;
    dout_d   = dout;
    dvalid_d = 1'b0;
    abort_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // mode is looked at only here, so a change mid-grant has no effect.
        if ((|req) && (mode != MODE_FROZEN)) begin
          state_d = GRANT;
          cnt_d   = HOLD_LOAD;
          if (mode == MODE_FIXED) begin
            idx_d = fp_idx;
          end else begin
            idx_d = rr_idx;
            ptr_d = rr_idx;
          end
          gnt_d = 4'b0001 << idx_d;
        end
      end
      GRANT: begin
        if (!req[idx_q]) begin
          // The winner withdrew: end the grant without sampling.
          state_d = IDLE;
          gnt_d   = 4'b0000;
          cnt_d   = 4'd0;
          abort_d = 1'b1;
        end else if (cnt_q == 4'd0) begin
          state_d  = SAMPLE;
          gnt_d    = 4'b0000;
          dout_d   = din[idx_q*W +: W];
          dvalid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      SAMPLE: begin
        // This IDLE cycle is the minimum gap before the next grant.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  // State and registered outputs. Reset clears them at once and drops any transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      ptr_q   <= 2'd3;
      idx_q   <= 2'd0;
      gnt     <= 4'b0000;
      dout    <= '0;
      dvalid  <= 1'b0;
      abort   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so that every flop samples the pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      gnt     <= gnt_d;
      dout    <= dout_d;
      dvalid  <= dvalid_d;
      abort   <= abort_d;
    end
  end

endmodule

// File: tb/tb_rr_sample_arbiter.sv
// Directed bench for rr_sample_arbiter. Stimulus pushes each expected grant,
// data and abort event, with its clock-edge number, into a queue. A monitor
// pops and compares the queue whenever the DUT presents one of these events.
module tb_rr_sample_arbiter;

  localparam int HOLD = 2;
  localparam int W    = 4;

  typedef enum logic [1:0] {EV_GNT, EV_DATA, EV_ABORT} ev_t;
  typedef struct {
    ev_t         kind;
    logic [31:0] val;
    int          cyc;
  } exp_t;

  logic           clk = 1'b0;
  logic           reset;
  logic [3:0]     req;
  logic [4*W-1:0] din;
  logic [1:0]     mode;
  logic [3:0]     gnt;
  logic           busy;
  logic [W-1:0]   dout;
  logic           dvalid;
  logic           abort;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t sb_q[$];

  rr_sample_arbiter #(.HOLD(HOLD), .W(W)) dut (
    .clk(clk), .reset(reset), .req(req), .din(din), .mode(mode),
    .gnt(gnt), .busy(busy), .dout(dout), .dvalid(dvalid), .abort(abort)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input ev_t kind, input logic [31:0] val, input int at);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    e.cyc  = at;
    sb_q.push_back(e);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: compare each event the DUT presents against the queue head.
  task automatic observe(input ev_t kind, input logic [31:0] val);
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s: got val %0h at edge %0d, nothing expected", kind.name(), val, cyc);
    end else begin
      e = sb_q.pop_front();
      if (e.kind != kind || e.val !== val || e.cyc != cyc) begin
        errors++;
        $display("FAIL event: got %s val %0h edge %0d, expected %s val %0h edge %0d",
                 kind.name(), val, cyc, e.kind.name(), e.val, e.cyc);
      end
    end
  endtask

  logic [3:0] prev_gnt = 4'b0000;
  always @(negedge clk) begin
    checks++;
    if (!$onehot0(gnt) || (dvalid && abort)) begin
      errors++;
      $display("FAIL invariant: gnt=%b dvalid=%b abort=%b", gnt, dvalid, abort);
    end
    if (gnt != 4'b0000 && gnt != prev_gnt) observe(EV_GNT, 32'(gnt));
    if (dvalid) observe(EV_DATA, 32'(dout));
    if (abort)  observe(EV_ABORT, 32'(dout));
    prev_gnt = gnt;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [W-1:0] slice [4];
  int base;

  initial begin
    slice[0] = 4'hA; slice[1] = 4'hB; slice[2] = 4'hC; slice[3] = 4'hD;
    reset = 1'b1;
    req   = 4'b0000;
    mode  = 2'b00;
    din   = {slice[3], slice[2], slice[1], slice[0]};

    // All outputs must sit low while reset is held.
    repeat (2) @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_dout", 32'(dout), 32'h0);
    check("rst_dvalid", 32'(dvalid), 32'h0);
    check("rst_abort", 32'(abort), 32'h0);

    // Round-robin with all four requesting: 0,1,2,3,0 with 4 edges per grant.
    @(negedge clk);
    reset = 1'b0;
    req   = 4'b1111;
    base  = cyc;
    for (int g = 0; g < 5; g++) begin
      push(EV_GNT, 32'(4'b0001 << (g % 4)), base + 1 + 4 * g);
      push(EV_DATA, 32'(slice[g % 4]), base + 1 + 4 * g + HOLD);
    end
    wait_cyc(base + 19);
    req = 4'b0000;
    wait_cyc(base + 21);
    check("rr_idle_after", 32'(busy), 32'h0);

    // Fixed priority with req 1010: requester 1 wins every time.
    mode = 2'b11;
    req  = 4'b1010;
    base = cyc;
    push(EV_GNT, 32'h2, base + 1);
    push(EV_DATA, 32'(slice[1]), base + 3);
    push(EV_GNT, 32'h2, base + 5);
    push(EV_DATA, 32'(slice[1]), base + 7);
    wait_cyc(base + 7);
    req = 4'b0000;
    wait_cyc(base + 9);
    // ptr is still 0, so round-robin now picks 1. If ptr had moved to 1, it would pick 3.
    mode = 2'b00;
    req  = 4'b1010;
    base = cyc;
    push(EV_GNT, 32'h2, base + 1);
    push(EV_DATA, 32'(slice[1]), base + 3);
    wait_cyc(base + 3);
    req = 4'b0000;
    wait_cyc(base + 5);

    // Requester 2 withdraws on its first GRANT cycle: abort, dout keeps B.
    req  = 4'b0100;
    base = cyc;
    push(EV_GNT, 32'h4, base + 1);
    push(EV_ABORT, 32'(slice[1]), base + 2);
    wait_cyc(base + 1);
    req = 4'b0000;
    wait_cyc(base + 2);
    check("abort_gnt_clear", 32'(gnt), 32'h0);
    wait_cyc(base + 4);
    check("abort_dout_kept", 32'(dout), 32'(slice[1]));

    // Single requester 1 with new data: dvalid arrives HOLD edges after gnt.
    slice[1] = 4'h5;
    din      = {slice[3], slice[2], slice[1], slice[0]};
    req      = 4'b0010;
    base     = cyc;
    push(EV_GNT, 32'h2, base + 1);
    push(EV_DATA, 32'h5, base + 1 + HOLD);
    wait_cyc(base + 1 + HOLD);
    req = 4'b0000;
    wait_cyc(base + 3 + HOLD);

    // Freeze mid-grant: the grant in progress completes, then no new grants.
    req  = 4'b1111;
    base = cyc;
    push(EV_GNT, 32'h4, base + 1);
    push(EV_DATA, 32'(slice[2]), base + 3);
    wait_cyc(base + 1);
    mode = 2'b10;
    wait_cyc(base + 5);
    for (int i = 0; i < 6; i++) begin
      check("frozen_busy", 32'(busy), 32'h0);
      @(negedge clk);
    end

    // Asynchronous reset mid-GRANT, then the first grant goes to requester 0.
    mode = 2'b00;
    base = cyc;
    push(EV_GNT, 32'h8, base + 1);
    wait_cyc(base + 1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_gnt", 32'(gnt), 32'h0);
    check("async_rst_busy", 32'(busy), 32'h0);
    check("async_rst_pulses", 32'({dvalid, abort}), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    base  = cyc;
    push(EV_GNT, 32'h1, base + 1);
    push(EV_DATA, 32'(slice[0]), base + 3);
    wait_cyc(base + 3);
    req = 4'b0000;
    wait_cyc(base + 6);

    check("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
